// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants for the seven-segment scan decoder.
//   * SEG_0 .. SEG_F : active-high lit-segment patterns, bit order g..a (bit6=g, bit0=a)
//   * SEG_TABLE      : the same 16 patterns indexed by hex value
//   * SEG_BLANK      : active-high pattern of a dark digit (no segment lit)
//   * NUM_DIGITS     : number of multiplexed digits on the anode bus
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode -- combinational lookup from a sampled segment bus to a hex nibble.
// Ports:
//   segments : input  [6:0] segment lines as seen on the pins, active-low, bit0=a .. bit6=g
//   nibble   : output [3:0] hex value of the pattern (0 when not legal)
//   legal    : output       pattern is one of the 16 hex glyphs
//   blank    : output       no segment lit (dark digit); never legal
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  logic [6:0] lit;

  // Pins are active-low; the table is kept in the readable active-high form.
  assign lit = ~segments;

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    blank  = (lit == SEG_BLANK);
    for (int v = 0; v < 16; v++) begin
      if (lit == SEG_TABLE[v]) begin
        nibble = 4'(v);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder -- recovers the hex digits shown on a multiplexed 4-digit
// seven-segment display by watching its anode and segment lines.
// A (digit, pattern) pair has to be seen on STABLE_CNT consecutive cycles before
// it is committed, which rejects ghosting while the scanner switches digits.
// Ports:
//   clk         : input        system clock, rising edge
//   rst         : input        synchronous active-high reset, highest priority
//   an          : input  [3:0] anode enables, active-low, an[k]=0 selects digit k
//   segments    : input  [6:0] segment lines, active-low, bit0=a .. bit6=g
//   clear       : input        synchronous soft clear of flags/valid/seen (digits kept)
//   digits      : output [15:0] decoded nibbles, digit k in digits[4k+3:4k]
//   digit_valid : output [3:0] bit k set while digit k holds a legally decoded value
//   frame_valid : output       one-cycle pulse once all four digits were refreshed
//   bad_pattern : output       sticky flag for an illegal lit-segment pattern
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CNT = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  segments,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        bad_pattern
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
  localparam logic [3:0] CNT_PRE = 4'(STABLE_CNT - 1);

  // Registered state
  logic [3:0]  cnt;
  logic [10:0] prev_pair;
  logic [3:0]  seen;

  // Next-state values
  logic [3:0]  cnt_n;
  logic [15:0] digits_n;
  logic [3:0]  valid_n;
  logic [3:0]  seen_n;
  logic        bad_n;
  logic        frame_n;

  // Sample qualification
  logic        an_ok;
  logic [1:0]  idx;
  logic        match;
  logic        commit;

  logic [3:0]  dec_nibble;
  logic        dec_legal;
  logic        dec_blank;

  seg_pattern_decode u_decode (
    .segments (segments),
    .nibble   (dec_nibble),
    .legal    (dec_legal),
    .blank    (dec_blank)
  );

  // Exactly one anode low selects a digit; anything else is a scanner gap.
  always_comb begin
    an_ok = 1'b1;
    idx   = 2'd0;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  // The anode is part of the compared pair, so moving to another digit with
  // the same glyph still starts a fresh run.
  assign match = ({an, segments} == prev_pair);

  // Commit fires only on the step into CNT_MAX; a saturated counter stays put.
  assign commit = an_ok && match && (cnt == CNT_PRE);

  always_comb begin
    if (!an_ok) begin
      cnt_n = 4'd0;
    end else if (match) begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
    end else begin
      cnt_n = 4'd1;
    end
  end

  always_comb begin
    digits_n = digits;
    valid_n  = digit_valid;
    seen_n   = seen;
    bad_n    = bad_pattern;
    frame_n  = 1'b0;

    if (commit) begin
      if (dec_legal) begin
        digits_n[{idx, 2'b00} +: 4] = dec_nibble;
        valid_n[idx]                = 1'b1;
        seen_n[idx]                 = 1'b1;
      end else if (dec_blank) begin
        valid_n[idx] = 1'b0;
      end else begin
        valid_n[idx] = 1'b0;
        bad_n        = 1'b1;
      end
    end

    // seen never registers as all-ones: the completing edge raises the
    // pulse and empties the mask together.
    if (seen_n == 4'hF) begin
      frame_n = 1'b1;
      seen_n  = 4'h0;
    end

    // Soft clear drops any same-cycle commit; the counter keeps running.
    if (clear) begin
      digits_n = digits;
      valid_n  = 4'h0;
      seen_n   = 4'h0;
      bad_n    = 1'b0;
      frame_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      prev_pair   <= 11'd0;
      seen        <= 4'h0;
      digits      <= 16'h0000;
      digit_valid <= 4'h0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      prev_pair   <= {an, segments};
      seen        <= seen_n;
      digits      <= digits_n;
      digit_valid <= valid_n;
      frame_valid <= frame_n;
      bad_pattern <= bad_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int N = 4;

  // Active-high glyphs g..a, indexed by hex value.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  an;
  logic [6:0]  segments;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        bad_pattern;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CNT(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .segments    (segments),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- behavioural model ----------------
  // A run is the number of consecutive cycles the same (an, segments) pair was
  // seen with a single digit selected; the commit happens when it hits N.
  int          run;
  logic [10:0] last_pair;
  logic [3:0]  m_nib  [4];
  bit          m_val  [4];
  bit          m_seen [4];
  bit          m_bad;
  bit          m_frame;

  function automatic logic [6:0] pins_of(input int v);
    logic [6:0] g;
    g = GLYPH[v];
    return ~g;
  endfunction

  // Returns hex value, 16 for blank, -1 for illegal.
  function automatic int glyph_value(input logic [6:0] pins);
    logic [6:0] lit;
    lit = ~pins;
    if (lit == 7'd0) return 16;
    for (int v = 0; v < 16; v++) if (GLYPH[v] == lit) return v;
    return -1;
  endfunction

  function automatic logic [15:0] m_digits();
    return {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
  endfunction

  function automatic logic [3:0] m_valid();
    return {m_val[3], m_val[2], m_val[1], m_val[0]};
  endfunction

  task automatic model_update(input logic [3:0] a, input logic [6:0] s,
                              input logic c, input logic r);
    int zeros, k, v;
    m_frame = 0;
    if (r) begin
      run = 0; last_pair = '0; m_bad = 0;
      for (int i = 0; i < 4; i++) begin m_nib[i] = 0; m_val[i] = 0; m_seen[i] = 0; end
      return;
    end
    zeros = 0; k = 0;
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) begin zeros++; k = i; end
    if (zeros != 1)            run = 0;
    else if ({a, s} == last_pair) run++;
    else                       run = 1;
    last_pair = {a, s};
    if (c) begin
      m_bad = 0;
      for (int i = 0; i < 4; i++) begin m_val[i] = 0; m_seen[i] = 0; end
      return;
    end
    if (zeros == 1 && run == N) begin
      v = glyph_value(s);
      if (v >= 0 && v < 16) begin
        m_nib[k] = 4'(v); m_val[k] = 1; m_seen[k] = 1;
      end else begin
        m_val[k] = 0;
        if (v < 0) m_bad = 1;
      end
    end
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      m_frame = 1;
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
      exp_q.push_back(m_digits());
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] a, input logic [6:0] s,
                      input logic c = 1'b0, input logic r = 1'b0);
    logic [15:0] exp_d;
    an = a; segments = s; clear = c; rst = r;
    @(posedge clk);
    model_update(a, s, c, r);
    #1;
    chk("digits", digits, m_digits());
    chk("digit_valid", 16'(digit_valid), 16'(m_valid()));
    chk("frame_valid", 16'(frame_valid), 16'(m_frame));
    chk("bad_pattern", 16'(bad_pattern), 16'(m_bad));
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", 16'(frame_valid), 16'd0);
      end else begin
        exp_d = exp_q.pop_front();
        chk("frame_digits", digits, exp_d);
      end
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int cycles);
    for (int i = 0; i < cycles; i++) step(a, s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    int         len;

    // Reset state
    step(4'hF, 7'h7F, 1'b0, 1'b1);
    step(4'hF, 7'h7F, 1'b1, 1'b1);
    chk("reset_digits", digits, 16'h0000);
    chk("reset_flags", {11'd0, digit_valid, frame_valid}, 16'd0);

    // Single digit 5, commit after exactly N edges, no re-commit while held
    hold(4'b1110, 7'b0010010, 3);
    chk("lat_not_yet", 16'(digit_valid), 16'h0);
    step(4'b1110, 7'b0010010);
    chk("lat_commit_digit", 16'(digits[3:0]), 16'h5);
    chk("lat_commit_valid", 16'(digit_valid), 16'h1);
    hold(4'b1110, 7'b0010010, 6);
    chk("held_no_frame", 16'(frame_valid), 16'h0);

    // Full frame 1, 2, A, F
    hold(4'b1110, pins_of(1), 4);
    hold(4'b1101, pins_of(2), 4);
    hold(4'b1011, pins_of(10), 4);
    hold(4'b0111, pins_of(15), 3);
    chk("frame_not_yet", 16'(frame_valid), 16'h0);
    step(4'b0111, pins_of(15));
    chk("frame_digits_fixed", digits, 16'hFA21);
    chk("frame_valid_all", 16'(digit_valid), 16'hF);
    chk("frame_pulse_hi", 16'(frame_valid), 16'h1);
    step(4'b0111, pins_of(15));
    chk("frame_pulse_lo", 16'(frame_valid), 16'h0);

    // Illegal pattern on digit 1, sticky until clear
    hold(4'b1101, 7'b1010101, 4);
    chk("bad_set", 16'(bad_pattern), 16'h1);
    chk("bad_valid1", 16'(digit_valid[1]), 16'h0);
    chk("bad_nibble_held", 16'(digits[7:4]), 16'h2);
    hold(4'b1110, pins_of(3), 6);
    chk("bad_sticky", 16'(bad_pattern), 16'h1);
    step(4'b1110, pins_of(3), 1'b1);
    chk("bad_cleared", 16'(bad_pattern), 16'h0);
    chk("clear_valid", 16'(digit_valid), 16'h0);
    chk("clear_keeps_digits", digits, 16'hFA23);

    // Blank after a valid 7 on digit 2
    hold(4'b1011, pins_of(7), 4);
    chk("seven_valid", 16'(digit_valid[2]), 16'h1);
    hold(4'b1011, 7'h7F, 4);
    chk("blank_valid", 16'(digit_valid[2]), 16'h0);
    chk("blank_nibble", 16'(digits[11:8]), 16'h7);
    chk("blank_not_bad", 16'(bad_pattern), 16'h0);

    // Invalid anode states and a pattern toggling too fast
    hold(4'b1100, pins_of(8), 10);
    hold(4'b1111, pins_of(8), 10);
    chk("gap_no_commit", 16'(digit_valid), 16'h0);
    for (int t = 0; t < 4; t++) begin
      hold(4'b0111, pins_of(8), 3);
      hold(4'b0111, 7'b1010101, 3);
    end
    chk("toggle_digit3", 16'(digits[15:12]), 16'hF);
    chk("toggle_no_bad", 16'(bad_pattern), 16'h0);

    // Same glyph, new anode mid-run restarts the count
    hold(4'b1110, pins_of(6), 2);
    hold(4'b1101, pins_of(6), 3);
    chk("anode_restart_wait", 16'(digit_valid), 16'h0);
    step(4'b1101, pins_of(6));
    chk("anode_restart_commit", 16'(digits[7:4]), 16'h6);

    // Clear coinciding with commit drops it; saturation forbids a retry
    hold(4'b1110, pins_of(9), 3);
    step(4'b1110, pins_of(9), 1'b1);
    hold(4'b1110, pins_of(9), 5);
    chk("clear_wins", 16'(digit_valid[0]), 16'h0);

    // Reset during the third cycle of a run
    hold(4'b1110, pins_of(12), 2);
    step(4'b1110, pins_of(12), 1'b0, 1'b1);
    chk("midrun_reset", {digits[14:0], frame_valid}, 16'h0);
    hold(4'b1110, pins_of(12), 3);
    chk("midrun_wait", 16'(digit_valid), 16'h0);
    step(4'b1110, pins_of(12));
    chk("midrun_commit", 16'(digits[3:0]), 16'hC);

    // Randomized scan
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        ra = 4'hF;
        ra[$urandom_range(0, 3)] = 1'b0;
      end else begin
        ra = 4'($urandom_range(0, 15));
      end
      case ($urandom_range(0, 7))
        0:       rs = 7'h7F;
        1, 2:    rs = 7'($urandom_range(0, 127));
        default: rs = pins_of($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++)
        step(ra, rs, ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
    end

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
